vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between display scanout and two write requesters: A (CPU) and B (drawing engine).
- Sits between the VGA timing generator, which supplies the pixel strobe, active and blanking flags, and the framebuffer RAM.
- Scanout reads have absolute priority and are never stalled.
- Writers share the remaining slots round-robin, optionally restricted to blanking.
- Keeps a per-frame count of writer stall cycles.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- WR_BLANK_ONLY, 0. When 1, writes are granted only while i_blanking=1.
- STALL_W, 16, width of the stall counters.

Ports:
- i_clk  in  1  base clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pix_stb  in  1  pixel strobe from the timing generator
- i_active  in  1  active-drawing flag from the timing generator
- i_blanking  in  1  blanking flag from the timing generator
- i_screenend  in  1  one-tick end-of-screen pulse
- i_disp_addr  in  ADDR_W  scanout address for the current pixel
- o_disp_data  out  DATA_W  scanout pixel data
- o_disp_valid  out  1  o_disp_data valid, one-cycle pulse
- i_wra_valid / o_wra_ready  in/out  1  writer A handshake
- i_wra_addr  in  ADDR_W  writer A address
- i_wra_data  in  DATA_W  writer A data
- i_wrb_valid / o_wrb_ready  in/out  1  writer B handshake
- i_wrb_addr  in  ADDR_W  writer B address
- i_wrb_data  in  DATA_W  writer B data
- o_mem_en  out  1  RAM enable
- o_mem_we  out  1  RAM write enable
- o_mem_addr  out  ADDR_W  RAM address
- o_mem_wdata  out  DATA_W  RAM write data
- i_mem_rdata  in  DATA_W  RAM read data, valid one cycle after the enabled read
- o_stall_cnt  out  STALL_W  stall cycles so far in the current frame
- o_stall_last  out  STALL_W  stall total of the previous frame

Behaviour:
- Reset: i_rst_n=0 asynchronously clears all registers.
  - o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata = 0.
  - o_disp_valid, o_disp_data = 0.
  - Both stall counters = 0.
  - Round-robin pointer = "A next".
  - Release is synchronous to i_clk.
- Reset mid-operation: in-flight reads are discarded (no o_disp_valid afterwards). Write handshakes not yet completed are not performed.
- Per-cycle arbitration is combinational, decided in cycle N:
  - disp_req = i_pix_stb & i_active. If set, the slot is a scanout read of i_disp_addr and both ready signals are 0.
  - Otherwise, a writer is eligible when its valid=1 and (WR_BLANK_ONLY=0 or i_blanking=1).
  - One writer eligible: it gets ready=1.
  - Both eligible: the pointer selects. Pointer "A next" grants A, "B next" grants B.
  - At most one ready is asserted per cycle. Ready never asserts without the corresponding valid.
- Handshake: a transfer occurs when valid & ready. Writers must hold addr/data stable while valid=1 and ready=0.
- Pointer update: only on a granted write. After an A grant the pointer becomes "B next"; after a B grant it becomes "A next". Scanout and idle cycles leave it unchanged.
- Memory command: registered in cycle N+1.
  - Read: en=1, we=0, addr=i_disp_addr.
  - Write: en=1, we=1, addr/wdata from the granted writer.
  - Idle: en=0, we=0; addr and wdata hold their last values.
- Scanout latency:
  - RAM returns data in N+2.
  - o_disp_data is registered from i_mem_rdata; o_disp_valid=1 in cycle N+3, for exactly one cycle per scanout read.
  - Fixed latency: 3 cycles from the strobe. Back-to-back strobes are fully pipelined.
- Stall counting:
  - stall = (i_wra_valid | i_wrb_valid) & no write granted this cycle. This includes cycles blocked by scanout or by WR_BLANK_ONLY.
  - A cycle where one writer is granted while the other waits is not a stall.
  - o_stall_cnt increments on stall and saturates at all-ones (no wrap).
- End of frame, i_screenend=1:
  - o_stall_last <= o_stall_cnt + stall, saturating.
  - o_stall_cnt <= 0; the current cycle's stall goes only into o_stall_last.
- Scanout request coinciding with a reset release edge: the request is arbitrated normally on the first clock after release.

Test Plan:
- Scanout only: i_pix_stb & i_active on cycles 0-3, addrs 0x0010-0x0013, RAM model returns addr[7:0] -> o_mem_en=1, we=0 on cycles 1-4; o_disp_valid on cycles 3-6 with data 0x10-0x13; both readies 0 throughout.
- Contention: A and B both hold valid for 4 cycles, no scanout, pointer "A next" after reset -> grants A,B,A,B; o_mem_we=1 with the matching addr/data one cycle after each grant; o_stall_cnt stays 0.
- Scanout priority: A valid continuously, strobe active on alternate cycles -> A is granted only on non-strobe cycles; no scanout read is ever lost; o_stall_cnt increases by 1 per strobe cycle.
- WR_BLANK_ONLY=1: B valid with i_blanking=0 for 10 cycles, then i_blanking=1 -> o_wrb_ready=0 for 10 cycles, o_stall_cnt=10, write granted on cycle 10.
- Frame boundary: o_stall_cnt=0x0005, stall occurring in the same cycle as the i_screenend pulse -> o_stall_last=0x0006, o_stall_cnt=0 next cycle; separately, preload near saturation and confirm the counter holds at 0xFFFF.
- Mid-operation reset: assert i_rst_n=0 one cycle after a scanout strobe -> all outputs 0 immediately; no o_disp_valid after release; pointer back to "A next" (next tie grants A).

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: scanout reads take every strobed slot, two writers
// share the rest round-robin, per-frame stall statistics.
module vram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter bit WR_BLANK_ONLY = 1'b0,
  parameter int STALL_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_stb,
  input  logic              i_active,
  input  logic              i_blanking,
  input  logic              i_screenend,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_wra_valid,
  output logic              o_wra_ready,
  input  logic [ADDR_W-1:0] i_wra_addr,
  input  logic [DATA_W-1:0] i_wra_data,
  input  logic              i_wrb_valid,
  output logic              o_wrb_ready,
  input  logic [ADDR_W-1:0] i_wrb_addr,
  input  logic [DATA_W-1:0] i_wrb_data,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [STALL_W-1:0] o_stall_cnt,
  output logic [STALL_W-1:0] o_stall_last
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_t;

  localparam logic [STALL_W-1:0] SAT = '1;
  localparam logic [STALL_W-1:0] ONE = STALL_W'(1);

  ptr_t ptr_q;
  ptr_t ptr_d;

  logic disp_req;
  logic wr_ok;
  logic elig_a;
  logic elig_b;
  logic gnt_a;
  logic gnt_b;
  logic gnt;
  logic stall;
  logic rd_q;
  logic [STALL_W-1:0] cnt_sum;

  assign disp_req = i_pix_stb & i_active;
  assign wr_ok    = ~WR_BLANK_ONLY | i_blanking;
  assign elig_a   = ~disp_req & wr_ok & i_wra_valid;
  assign elig_b   = ~disp_req & wr_ok & i_wrb_valid;
  assign gnt      = gnt_a | gnt_b;
  assign stall    = (i_wra_valid | i_wrb_valid) & ~gnt;

  assign o_wra_ready = gnt_a;
  assign o_wrb_ready = gnt_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_a) begin
      ptr_d = PTR_B;
    end else if (gnt_b) begin
      ptr_d = PTR_A;
    end
  end

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      elig_a && elig_b: begin
        gnt_a = (ptr_q == PTR_A);
        gnt_b = (ptr_q == PTR_B);
      end
      elig_a && !elig_b: gnt_a = 1'b1;
      !elig_a && elig_b: gnt_b = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_en <= disp_req | gnt;
      o_mem_we <= gnt;
      if (disp_req) begin
        o_mem_addr <= i_disp_addr;
      end else if (gnt_a) begin
        o_mem_addr  <= i_wra_addr;
        o_mem_wdata <= i_wra_data;
      end else if (gnt_b) begin
        o_mem_addr  <= i_wrb_addr;
        o_mem_wdata <= i_wrb_data;
      end
    end
  end

  // rd_q marks the cycle the RAM drives read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q         <= 1'b0;
      o_disp_valid <= 1'b0;
      o_disp_data  <= '0;
    end else begin
      rd_q         <= o_mem_en & ~o_mem_we;
      o_disp_valid <= rd_q;
      if (rd_q) begin
        o_disp_data <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    cnt_sum = o_stall_cnt;
    if (stall && o_stall_cnt != SAT) begin
      cnt_sum = o_stall_cnt + ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt  <= '0;
      o_stall_last <= '0;
    end else if (i_screenend) begin
      o_stall_last <= cnt_sum;
      o_stall_cnt  <= '0;
    end else begin
      o_stall_cnt <= cnt_sum;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (free writes / blank-only
// with narrow counters) against a cycle-level reference model.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stb, act, blank, send, va, vb;
  logic [15:0] daddr, aaddr, baddr;
  logic [7:0]  adata, bdata;

  logic        dvalid [2];
  logic [7:0]  ddata  [2];
  logic        rdy_a  [2];
  logic        rdy_b  [2];
  logic        men    [2];
  logic        mwe    [2];
  logic [15:0] maddr  [2];
  logic [7:0]  mwdata [2];
  logic [7:0]  rdata  [2];
  logic [15:0] scnt0, slast0;
  logic [3:0]  scnt1, slast1;

  vram_arbiter #(.WR_BLANK_ONLY(1'b0), .STALL_W(16)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_active(act),
    .i_blanking(blank), .i_screenend(send), .i_disp_addr(daddr),
    .o_disp_data(ddata[0]), .o_disp_valid(dvalid[0]),
    .i_wra_valid(va), .o_wra_ready(rdy_a[0]),
    .i_wra_addr(aaddr), .i_wra_data(adata),
    .i_wrb_valid(vb), .o_wrb_ready(rdy_b[0]),
    .i_wrb_addr(baddr), .i_wrb_data(bdata),
    .o_mem_en(men[0]), .o_mem_we(mwe[0]), .o_mem_addr(maddr[0]),
    .o_mem_wdata(mwdata[0]), .i_mem_rdata(rdata[0]),
    .o_stall_cnt(scnt0), .o_stall_last(slast0)
  );

  vram_arbiter #(.WR_BLANK_ONLY(1'b1), .STALL_W(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_active(act),
    .i_blanking(blank), .i_screenend(send), .i_disp_addr(daddr),
    .o_disp_data(ddata[1]), .o_disp_valid(dvalid[1]),
    .i_wra_valid(va), .o_wra_ready(rdy_a[1]),
    .i_wra_addr(aaddr), .i_wra_data(adata),
    .i_wrb_valid(vb), .o_wrb_ready(rdy_b[1]),
    .i_wrb_addr(baddr), .i_wrb_data(bdata),
    .o_mem_en(men[1]), .o_mem_we(mwe[1]), .o_mem_addr(maddr[1]),
    .o_mem_wdata(mwdata[1]), .i_mem_rdata(rdata[1]),
    .o_stall_cnt(scnt1), .o_stall_last(slast1)
  );

  logic       ram_init;
  logic [7:0] ram [2][256];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_init) begin
        for (int i = 0; i < 256; i++) ram[k][i] <= 8'(i);
      end else if (men[k]) begin
        if (mwe[k]) ram[k][maddr[k][7:0]] <= mwdata[k];
        else rdata[k] <= ram[k][maddr[k][7:0]];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int         cyc;
  logic       m_ptrb [2];
  logic       m_en   [2];
  logic       m_we   [2];
  logic [15:0] m_addr [2];
  logic [7:0] m_wd   [2];
  logic [7:0] m_dd   [2];
  int         m_cnt  [2];
  int         m_last [2];
  int         smax   [2];
  logic [7:0] fb     [2][256];
  logic       pw_v   [2];
  logic [7:0] pw_a   [2];
  logic [7:0] pw_d   [2];
  logic       exp_v  [2][4];
  logic [7:0] exp_d  [2][4];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptrb[k] = 0; m_en[k] = 0; m_we[k] = 0;
      m_addr[k] = 0; m_wd[k] = 0; m_dd[k] = 0;
      m_cnt[k] = 0; m_last[k] = 0; pw_v[k] = 0;
      for (int s = 0; s < 4; s++) exp_v[k][s] = 0;
    end
  endtask

  task automatic grants(input int k, output logic ga, output logic gb,
                        output logic st);
    logic disp, ok, ca, cb;
    disp = stb & act;
    ok = (k == 0) || blank;
    ca = va & ~disp & ok;
    cb = vb & ~disp & ok;
    ga = ca & (~cb | ~m_ptrb[k]);
    gb = cb & (~ca | m_ptrb[k]);
    st = (va | vb) & ~(ga | gb);
  endtask

  task automatic sample();
    logic ga, gb, st;
    int slot;
    @(negedge clk);
    if (!rst_n) model_reset();
    slot = cyc % 4;
    for (int k = 0; k < 2; k++) begin
      grants(k, ga, gb, st);
      check($sformatf("rdyA%0d", k), 32'(rdy_a[k]), 32'(ga));
      check($sformatf("rdyB%0d", k), 32'(rdy_b[k]), 32'(gb));
      check($sformatf("en%0d", k), 32'(men[k]), 32'(m_en[k]));
      check($sformatf("we%0d", k), 32'(mwe[k]), 32'(m_we[k]));
      check($sformatf("addr%0d", k), 32'(maddr[k]), 32'(m_addr[k]));
      check($sformatf("wd%0d", k), 32'(mwdata[k]), 32'(m_wd[k]));
      check($sformatf("dv%0d", k), 32'(dvalid[k]), 32'(exp_v[k][slot]));
      if (exp_v[k][slot]) m_dd[k] = exp_d[k][slot];
      exp_v[k][slot] = 0;
      check($sformatf("dd%0d", k), 32'(ddata[k]), 32'(m_dd[k]));
    end
    check("cnt0", 32'(scnt0), 32'(m_cnt[0]));
    check("last0", 32'(slast0), 32'(m_last[0]));
    check("cnt1", 32'(scnt1), 32'(m_cnt[1]));
    check("last1", 32'(slast1), 32'(m_last[1]));
  endtask

  task automatic adv();
    logic ga, gb, st, disp;
    int tot;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      disp = stb & act;
      for (int k = 0; k < 2; k++) begin
        if (pw_v[k]) fb[k][pw_a[k]] = pw_d[k];
        pw_v[k] = 0;
        grants(k, ga, gb, st);
        if (disp) begin
          exp_v[k][(cyc + 3) % 4] = 1;
          exp_d[k][(cyc + 3) % 4] = fb[k][daddr[7:0]];
        end
        m_en[k] = disp | ga | gb;
        m_we[k] = ga | gb;
        if (disp) begin
          m_addr[k] = daddr;
        end else if (ga) begin
          m_addr[k] = aaddr; m_wd[k] = adata;
          pw_v[k] = 1; pw_a[k] = aaddr[7:0]; pw_d[k] = adata;
        end else if (gb) begin
          m_addr[k] = baddr; m_wd[k] = bdata;
          pw_v[k] = 1; pw_a[k] = baddr[7:0]; pw_d[k] = bdata;
        end
        if (ga) m_ptrb[k] = 1;
        else if (gb) m_ptrb[k] = 0;
        tot = m_cnt[k] + int'(st);
        if (tot > smax[k]) tot = smax[k];
        if (send) begin
          m_last[k] = tot; m_cnt[k] = 0;
        end else begin
          m_cnt[k] = tot;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic idle();
    stb = 0; act = 0; blank = 0; send = 0; va = 0; vb = 0;
    daddr = 0; aaddr = 0; baddr = 0; adata = 0; bdata = 0;
  endtask

  initial begin
    smax[0] = 65535;
    smax[1] = 15;
    cyc = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) fb[k][i] = 8'(i);
    model_reset();
    idle();
    ram_init = 1;
    step(); step(); step();
    ram_init = 0;
    rst_n = 1;
    step();

    for (int i = 0; i < 4; i++) begin
      stb = 1; act = 1; daddr = 16'h10 + 16'(i);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();

    va = 1; vb = 1;
    for (int i = 0; i < 4; i++) begin
      aaddr = 16'h20 + 16'(i); adata = 8'hA0 + 8'(i);
      baddr = 16'h30 + 16'(i); bdata = 8'hB0 + 8'(i);
      sample();
      check($sformatf("contA%0d", i), 32'(rdy_a[0]), 32'(i % 2 == 0));
      adv();
    end
    idle();
    step(); step();
    check("ramA0", 32'(ram[0][8'h20]), 32'h A0);
    check("ramB1", 32'(ram[0][8'h31]), 32'h B1);
    check("contStall", 32'(scnt0), 32'd0);

    va = 1; act = 1; aaddr = 16'h40; adata = 8'h55;
    for (int i = 0; i < 8; i++) begin
      stb = (i % 2 == 0); daddr = 16'(i);
      sample();
      check($sformatf("prio%0d", i), 32'(rdy_a[0]), 32'(i % 2 != 0));
      adv();
    end
    idle();
    sample();
    check("prioStall", 32'(scnt0), 32'd4);
    adv();
    send = 1; step(); idle();

    vb = 1; baddr = 16'h50; bdata = 8'h77;
    for (int i = 0; i < 10; i++) step();
    blank = 1;
    sample();
    check("blankCnt", 32'(scnt1), 32'd10);
    check("blankRdy", 32'(rdy_b[1]), 32'd1);
    adv();
    idle();
    send = 1; step(); idle();

    va = 1; stb = 1; act = 1;
    for (int i = 0; i < 5; i++) step();
    send = 1;
    sample();
    check("frameCnt5", 32'(scnt0), 32'd5);
    adv();
    idle();
    sample();
    check("frameLast", 32'(slast0), 32'd6);
    check("frameClr", 32'(scnt0), 32'd0);
    adv();

    va = 1; stb = 1; act = 1;
    for (int i = 0; i < 20; i++) step();
    idle();
    sample();
    check("satHold", 32'(scnt1), 32'hF);
    check("satCnt0", 32'(scnt0), 32'd20);
    adv();

    va = 1; step(); idle();
    stb = 1; act = 1; daddr = 16'h5; step();
    idle();
    rst_n = 0;
    sample();
    check("rstEn", 32'(men[0]), 32'd0);
    check("rstCnt", 32'(scnt0), 32'd0);
    adv();
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) step();
    va = 1; vb = 1;
    sample();
    check("tieA", 32'(rdy_a[0]), 32'd1);
    adv();
    idle();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      act = $urandom_range(0, 1);
      stb = ($urandom_range(0, 2) == 0);
      blank = $urandom_range(0, 1);
      send = ($urandom_range(0, 49) == 0);
      daddr = 16'($urandom_range(0, 15));
      va = ($urandom_range(0, 9) < 6);
      vb = ($urandom_range(0, 9) < 6);
      aaddr = 16'($urandom_range(0, 15));
      baddr = 16'($urandom_range(0, 15));
      adata = 8'($urandom);
      bdata = 8'($urandom);
      step();
    end
    rst_n = 1;
    idle();
    for (int i = 0; i < 5; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
